peripheral_mpi_bus_initiator: RTL

PERIPHERAL_MPI_BUS_INITIATOR -- requirements
Module: peripheral_mpi_bus_initiator

---
 rtl/peripheral_mpi_bus_initiator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/peripheral_mpi_bus_initiator.sv
// Single-outstanding generic-bus initiator: command in, bus cycle out, response back.
// Optional REQ-state abort when PERIPHERAL_MPI_BUS_TIMEOUT_EN is defined.
module peripheral_mpi_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic        bus_en,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  input  logic        bus_ack,
  input  logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        tmo_q;
  logic        hit;
  logic        tmo;
  logic        done;

  assign hit  = bus_ack | bus_err;
  assign done = (state == REQ) & (hit | tmo);

`ifdef PERIPHERAL_MPI_BUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  // Count REQ cycles with no completion; cleared whenever not in REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state != REQ) begin
      cnt <= '0;
    end else if (!hit) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tmo = (state == REQ) & ~hit & (cnt == TMO_LAST);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, finish REQ on ack/err/timeout, drain RESP.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nxt = REQ;
      REQ:  if (hit || tmo) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture and response capture; err beats ack, ack beats timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_data;
      end
      if (done) begin
        err_q   <= bus_err | tmo;
        tmo_q   <= tmo;
        rdata_q <= (bus_ack && !bus_err && !we_q) ? bus_data_in : '0;
      end
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign bus_en       = (state == REQ);
  assign bus_we       = (state == REQ) & we_q;
  assign bus_addr     = addr_q;
  assign bus_data_out = wdata_q;
  assign rsp_valid    = (state == RESP);
  assign rsp_data     = rdata_q;
  assign rsp_err      = err_q;
  assign rsp_timeout  = tmo_q;

endmodule
